// File: rtl/enable_tick_gen_pkg.sv
// -----------------------------------------------------------------------------
// tick_gen_pkg
// Shared types for the enable_tick_gen block.
//   tick_state_t : control FSM state encoding.
//   TICK_IDLE    : stopped; divisor may be loaded.
//   TICK_RUN     : prescaler counting; tick pulses are emitted.
// -----------------------------------------------------------------------------
package tick_gen_pkg;

  typedef enum logic [0:0] {
    TICK_IDLE = 1'b0,
    TICK_RUN  = 1'b1
  } tick_state_t;

endpackage : tick_gen_pkg

// File: rtl/enable_tick_gen_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Prescale counter that runs 0..div_reg-1 and emits a one-cycle tick on the
// terminal count.
// Ports:
//   clk      in  1          rising-edge clock
//   reset_n  in  1          asynchronous active-low reset
//   clear    in  1          synchronous clear of the count (has priority)
//   run      in  1          count enable; also qualifies tick
//   div_reg  in  DIV_WIDTH  current divisor, always >= 1
//   tick     out 1          run && (count == div_reg-1)
// -----------------------------------------------------------------------------
module tick_prescaler #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 run,
  input  logic [DIV_WIDTH-1:0] div_reg,
  output logic                 tick
);

  localparam logic [DIV_WIDTH-1:0] CNT_ONE  = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] CNT_ZERO = {DIV_WIDTH{1'b0}};

  logic [DIV_WIDTH-1:0] pre_cnt_r;
  logic                 wrap_s;

  // div_reg is never 0, so div_reg-1 cannot underflow.
  assign wrap_s = (pre_cnt_r == (div_reg - CNT_ONE));
  assign tick   = run && wrap_s;

  // Prescale count: clear wins, wrap to zero on a tick, otherwise advance while running.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt_r <= CNT_ZERO;
    end else if (clear) begin
      pre_cnt_r <= CNT_ZERO;
    end else if (tick) begin
      pre_cnt_r <= CNT_ZERO;
    end else if (run) begin
      pre_cnt_r <= pre_cnt_r + CNT_ONE;
    end else begin
      pre_cnt_r <= pre_cnt_r;
    end
  end

endmodule : tick_prescaler

// File: rtl/enable_tick_gen.sv
// -----------------------------------------------------------------------------
// enable_tick_gen
// Programmable tick generator: emits a one-cycle 'tick' every div_reg cycles
// while running, used as the enable of downstream modulo counters.
// Optional burst mode (fixed number of ticks per run) is built only when the
// macro ENABLE_TICK_GEN_BURST_EN is defined; otherwise every run is
// continuous and 'done' is tied low. The port list is the same either way.
// Ports:
//   clk        in  1            rising-edge clock
//   reset_n    in  1            asynchronous active-low reset
//   start      in  1            level; IDLE->RUN when high and stop low
//   stop       in  1            level; RUN->IDLE
//   div_valid  in  1            divisor load request
//   div_value  in  DIV_WIDTH    new divisor (0 is loaded as 1)
//   div_ready  out 1            load accepted only in IDLE
//   burst_len  in  BURST_WIDTH  ticks per run, 0 = continuous (latched at start)
//   tick       out 1            one-cycle enable pulse
//   running    out 1            high in RUN
//   done       out 1            registered pulse after the final burst tick
// -----------------------------------------------------------------------------
module enable_tick_gen
  import tick_gen_pkg::*;
#(
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 50000,
  parameter int BURST_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   div_valid,
  input  logic [DIV_WIDTH-1:0]   div_value,
  output logic                   div_ready,
  input  logic [BURST_WIDTH-1:0] burst_len,
  output logic                   tick,
  output logic                   running,
  output logic                   done
);

  localparam logic [DIV_WIDTH-1:0] DIV_ONE   = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] DIV_RESET = DIV_WIDTH'(DEFAULT_DIV);

  tick_state_t          state_r;
  tick_state_t          state_next_s;
  logic [DIV_WIDTH-1:0] div_reg_r;
  logic                 start_accept_s;
  logic                 div_load_s;
  logic                 clear_s;
  logic                 run_s;
  logic                 tick_s;
  logic                 burst_done_s;

  // A zero divisor would never reach its terminal count; load it as 1.
  function automatic logic [DIV_WIDTH-1:0] clamp_div(input logic [DIV_WIDTH-1:0] value);
    if (value == {DIV_WIDTH{1'b0}}) begin
      clamp_div = DIV_ONE;
    end else begin
      clamp_div = value;
    end
  endfunction

  assign run_s      = (state_r == TICK_RUN);
  assign div_ready  = (state_r == TICK_IDLE);
  assign running    = run_s;
  assign tick       = tick_s;
  assign div_load_s = div_valid && (state_r == TICK_IDLE);
  // Hold the prescaler at zero whenever the next cycle is IDLE, so a run
  // always starts from a clean count.
  assign clear_s    = (state_next_s == TICK_IDLE);

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= TICK_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state: stop beats start in IDLE; stop or burst end leaves RUN.
  always_comb begin
    state_next_s   = state_r;
    start_accept_s = 1'b0;
    case (state_r)
      TICK_IDLE: begin
        if (start && !stop) begin
          state_next_s   = TICK_RUN;
          start_accept_s = 1'b1;
        end else begin
          state_next_s   = TICK_IDLE;
        end
      end
      TICK_RUN: begin
        if (stop || burst_done_s) begin
          state_next_s = TICK_IDLE;
        end else begin
          state_next_s = TICK_RUN;
        end
      end
      default: begin
        state_next_s = TICK_IDLE;
      end
    endcase
  end

  // Divisor register: loads only while IDLE, kept across runs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_reg_r <= DIV_RESET;
    end else if (div_load_s) begin
      div_reg_r <= clamp_div(div_value);
    end else begin
      div_reg_r <= div_reg_r;
    end
  end

  tick_prescaler #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear_s),
    .run     (run_s),
    .div_reg (div_reg_r),
    .tick    (tick_s)
  );

`ifdef ENABLE_TICK_GEN_BURST_EN
  localparam logic [BURST_WIDTH-1:0] BURST_ZERO = {BURST_WIDTH{1'b0}};
  localparam logic [BURST_WIDTH-1:0] BURST_ONE  = BURST_WIDTH'(1);
  localparam logic [BURST_WIDTH-1:0] BURST_MAX  = {BURST_WIDTH{1'b1}};

  logic [BURST_WIDTH-1:0] burst_cnt_r;
  logic [BURST_WIDTH-1:0] burst_len_r;
  logic                   done_r;

  // The final tick of a nonzero burst ends the run.
  assign burst_done_s = run_s && tick_s && (burst_len_r != BURST_ZERO) &&
                        (burst_cnt_r == (burst_len_r - BURST_ONE));

  // Burst length latch and tick counter; the counter saturates in continuous mode.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      burst_cnt_r <= BURST_ZERO;
      burst_len_r <= BURST_ZERO;
    end else if (start_accept_s) begin
      burst_cnt_r <= BURST_ZERO;
      burst_len_r <= burst_len;
    end else if (clear_s) begin
      burst_cnt_r <= BURST_ZERO;
      burst_len_r <= burst_len_r;
    end else if (tick_s && (burst_cnt_r != BURST_MAX)) begin
      burst_cnt_r <= burst_cnt_r + BURST_ONE;
      burst_len_r <= burst_len_r;
    end else begin
      burst_cnt_r <= burst_cnt_r;
      burst_len_r <= burst_len_r;
    end
  end

  // Completion pulse lands in the first IDLE cycle after the final tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_r <= 1'b0;
    end else begin
      done_r <= burst_done_s;
    end
  end

  assign done = done_r;
`else
  logic unused_burst_s;

  assign burst_done_s   = 1'b0;
  assign done           = 1'b0;
  assign unused_burst_s = ^{burst_len, start_accept_s};
`endif

endmodule : enable_tick_gen

// File: tb/tb_enable_tick_gen.sv
module tb_enable_tick_gen;

  localparam int DW = 16;
  localparam int BW = 8;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic          stop;
  logic          div_valid;
  logic [DW-1:0] div_value;
  logic          div_ready;
  logic [BW-1:0] burst_len;
  logic          tick;
  logic          running;
  logic          done;

  int n_checks;
  int n_fail;

  enable_tick_gen #(
    .DIV_WIDTH   (DW),
    .DEFAULT_DIV (4),
    .BURST_WIDTH (BW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .stop      (stop),
    .div_valid (div_valid),
    .div_value (div_value),
    .div_ready (div_ready),
    .burst_len (burst_len),
    .tick      (tick),
    .running   (running),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset_n   = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    div_valid = 1'b0;
    div_value = 16'd0;
    burst_len = 8'd0;

    // Reset state
    step();
    step();
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_div_ready", 32'(div_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // Default divisor 4: ticks after edges 3, 7, 11
    start = 1'b1;
    step();
    start = 1'b0;
    chk("def_running", 32'(running), 32'd1);
    chk("def_div_ready", 32'(div_ready), 32'd0);
    for (int k = 0; k < 11; k++) begin
      chk($sformatf("def_tick_k%0d", k), 32'(tick), 32'((k % 4) == 3));
      step();
    end
    chk("def_tick_k11", 32'(tick), 32'd1);
    // Mid-run reset takes effect without a clock edge
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_tick", 32'(tick), 32'd0);
    chk("midrst_running", 32'(running), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_div_ready", 32'(div_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // Load divisor 3; ticks after edges 2, 5, 8; load during RUN ignored
    chk("ld3_div_ready", 32'(div_ready), 32'd1);
    div_valid = 1'b1;
    div_value = 16'd3;
    step();
    div_valid = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("d3_tick_k%0d", k), 32'(tick), 32'((k % 3) == 2));
      if (k == 3) begin
        div_valid = 1'b1;
        div_value = 16'd9;
        chk("d3_run_div_ready", 32'(div_ready), 32'd0);
      end
      if (k == 6) begin
        div_valid = 1'b0;
      end
      step();
    end
    // Stop coincident with a tick: tick still shown, then IDLE
    chk("stop_tick_k8", 32'(tick), 32'd1);
    stop = 1'b1;
    step();
    chk("stop_running", 32'(running), 32'd0);
    chk("stop_tick", 32'(tick), 32'd0);
    // start and stop together in IDLE stay IDLE
    start = 1'b1;
    step();
    chk("collide_running", 32'(running), 32'd0);
    chk("collide_div_ready", 32'(div_ready), 32'd1);
    start = 1'b0;
    stop = 1'b0;

    // Divisor 0 behaves as 1: tick every RUN cycle
    div_valid = 1'b1;
    div_value = 16'd0;
    step();
    div_valid = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("d0_tick_k%0d", k), 32'(tick), 32'd1);
      chk($sformatf("d0_running_k%0d", k), 32'(running), 32'd1);
      step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("d0_stop_running", 32'(running), 32'd0);
    chk("d0_stop_tick", 32'(tick), 32'd0);

    // Burst of 5 at divisor 2: ticks after edges 1, 3, 5, 7, 9
    div_valid = 1'b1;
    div_value = 16'd2;
    step();
    div_valid = 1'b0;
    burst_len = 8'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    burst_len = 8'd0;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("bu_tick_k%0d", k), 32'(tick), 32'((k % 2) == 1));
      chk($sformatf("bu_running_k%0d", k), 32'(running), 32'd1);
      chk($sformatf("bu_done_k%0d", k), 32'(done), 32'd0);
      step();
    end
`ifdef ENABLE_TICK_GEN_BURST_EN
    chk("bu_end_running", 32'(running), 32'd0);
    chk("bu_end_done", 32'(done), 32'd1);
    chk("bu_end_tick", 32'(tick), 32'd0);
    step();
    chk("bu_after_done", 32'(done), 32'd0);
    chk("bu_after_running", 32'(running), 32'd0);
`else
    chk("bu_cont_running_k10", 32'(running), 32'd1);
    chk("bu_cont_done_k10", 32'(done), 32'd0);
    chk("bu_cont_tick_k10", 32'(tick), 32'd0);
    step();
    chk("bu_cont_tick_k11", 32'(tick), 32'd1);
    chk("bu_cont_done_k11", 32'(done), 32'd0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("bu_cont_stop_running", 32'(running), 32'd0);
`endif

    // Load 7 together with start: first tick after edge 6, next after 13
    div_valid = 1'b1;
    div_value = 16'd7;
    start = 1'b1;
    step();
    div_valid = 1'b0;
    start = 1'b0;
    chk("ls_running", 32'(running), 32'd1);
    for (int k = 0; k < 14; k++) begin
      chk($sformatf("ls_tick_k%0d", k), 32'(tick), 32'((k % 7) == 6));
      step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("ls_stop_running", 32'(running), 32'd0);
    chk("ls_done", 32'(done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_enable_tick_gen
